// File: rtl/pulse_meter.sv
// pulse_meter: measures the high time and the period of a monitored signal.
// The signal is presented as edge pulses. A completed measurement is offered
// on a valid/ready output register.
//
// Ports
//   clk            : single clock, rising edge
//   reset          : asynchronous, active-low reset
//   rising_edge_i  : one-cycle pulse, 0->1 transition of the monitored signal
//   falling_edge_i : one-cycle pulse, 1->0 transition of the monitored signal
//   meas_valid_o   : a measurement is held on the outputs
//   meas_ready_i   : consumer accepts when meas_valid_o && meas_ready_i
//   high_cnt_o     : high time in clk cycles (saturating)
//   period_cnt_o   : period in clk cycles (saturating)
//   ovf_o          : a counter saturated during this measurement
//   drop_o         : one-cycle pulse, a completed measurement was discarded
module pulse_meter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rising_edge_i,
  input  logic             falling_edge_i,
  output logic             meas_valid_o,
  input  logic             meas_ready_i,
  output logic [CNT_W-1:0] high_cnt_o,
  output logic [CNT_W-1:0] period_cnt_o,
  output logic             ovf_o,
  output logic             drop_o
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_hcnt, r_pcnt;
  logic [CNT_W-1:0] w_hcnt_nxt, w_pcnt_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             w_cap;
  logic             w_rise, w_fall;

  logic             r_valid;
  logic [CNT_W-1:0] r_high_out, r_period_out;
  logic             r_ovf_out;
  logic             r_drop;

  // Saturating increment: the counter sticks at its maximum value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // True when the incremented value is (or stays) at the maximum.
  function automatic logic sat_hit(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) || (v == (CNT_MAX - CNT_ONE));
  endfunction

  // Coincident rise and fall cancel each other and act as "no pulse".
  assign w_rise = rising_edge_i & ~falling_edge_i;
  assign w_fall = falling_edge_i & ~rising_edge_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_hcnt  <= '0;
      r_pcnt  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_pcnt  <= w_pcnt_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = r_hcnt;
    w_pcnt_nxt  = r_pcnt;
    w_ovf_nxt   = r_ovf;
    w_cap       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_hcnt_nxt  = CNT_ONE;
          w_pcnt_nxt  = CNT_ONE;
          w_ovf_nxt   = 1'b0;
          w_state_nxt = HIGH;
        end
      end
      HIGH: begin
        if (w_rise) begin
          // Missed falling edge: start over from this rise, nothing reported.
          w_hcnt_nxt = CNT_ONE;
          w_pcnt_nxt = CNT_ONE;
          w_ovf_nxt  = 1'b0;
        end else if (w_fall) begin
          w_pcnt_nxt  = sat_inc(r_pcnt);
          w_ovf_nxt   = r_ovf | sat_hit(r_pcnt);
          w_state_nxt = LOW;
        end else begin
          w_hcnt_nxt = sat_inc(r_hcnt);
          w_pcnt_nxt = sat_inc(r_pcnt);
          w_ovf_nxt  = r_ovf | sat_hit(r_hcnt) | sat_hit(r_pcnt);
        end
      end
      LOW: begin
        if (w_rise) begin
          // Measurement complete: the pre-update counters are captured.
          w_cap       = 1'b1;
          w_hcnt_nxt  = CNT_ONE;
          w_pcnt_nxt  = CNT_ONE;
          w_ovf_nxt   = 1'b0;
          w_state_nxt = HIGH;
        end else begin
          w_pcnt_nxt = sat_inc(r_pcnt);
          w_ovf_nxt  = r_ovf | sat_hit(r_pcnt);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output register: a capture is taken if the slot is empty or being
  // emptied this cycle; otherwise it is dropped and the held data is kept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid      <= 1'b0;
      r_high_out   <= '0;
      r_period_out <= '0;
      r_ovf_out    <= 1'b0;
      r_drop       <= 1'b0;
    end else begin
      r_drop <= 1'b0;
      if (w_cap) begin
        if (!r_valid || meas_ready_i) begin
          r_valid      <= 1'b1;
          r_high_out   <= r_hcnt;
          r_period_out <= r_pcnt;
          r_ovf_out    <= r_ovf;
        end else begin
          r_drop <= 1'b1;
        end
      end else if (r_valid && meas_ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign meas_valid_o = r_valid;
  assign high_cnt_o   = r_high_out;
  assign period_cnt_o = r_period_out;
  assign ovf_o        = r_ovf_out;
  assign drop_o       = r_drop;

endmodule

// File: tb/tb_pulse_meter.sv
// Directed bench for pulse_meter. Cycle numbering: after reset release the
// bench is at cycle 0; a pulse "at cycle c" is driven during cycle c and
// sampled by the edge ending it; outputs read #1 after that edge belong to
// cycle c+1.
module tb_pulse_meter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rising_edge_i = 1'b0;
  logic        falling_edge_i = 1'b0;
  logic        meas_ready_i = 1'b0;

  logic        meas_valid_o;
  logic [15:0] high_cnt_o, period_cnt_o;
  logic        ovf_o, drop_o;

  logic        v4;
  logic [3:0]  h4, p4;
  logic        o4, d4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [34:0] obs;
  logic [10:0] obs4;
  assign obs  = {meas_valid_o, high_cnt_o, period_cnt_o, ovf_o, drop_o};
  assign obs4 = {v4, h4, p4, o4, d4};

  always #5 clk = ~clk;

  pulse_meter #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .rising_edge_i(rising_edge_i), .falling_edge_i(falling_edge_i),
    .meas_valid_o(meas_valid_o), .meas_ready_i(meas_ready_i),
    .high_cnt_o(high_cnt_o), .period_cnt_o(period_cnt_o),
    .ovf_o(ovf_o), .drop_o(drop_o)
  );

  pulse_meter #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset),
    .rising_edge_i(rising_edge_i), .falling_edge_i(falling_edge_i),
    .meas_valid_o(v4), .meas_ready_i(meas_ready_i),
    .high_cnt_o(h4), .period_cnt_o(p4),
    .ovf_o(o4), .drop_o(d4)
  );

  task automatic tick(input logic r, input logic f);
    rising_edge_i  = r;
    falling_edge_i = f;
    @(posedge clk);
    #1;
    rising_edge_i  = 1'b0;
    falling_edge_i = 1'b0;
    cyc++;
  endtask

  task automatic go(input int c);
    while (cyc < c) tick(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rising_edge_i  = 1'b0;
    falling_edge_i = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    if (obs !== 35'd0) begin
      errors++; $display("FAIL reset_outs got %h exp 0", obs);
    end
    checks++;
    if (obs4 !== 11'd0) begin
      errors++; $display("FAIL reset_outs_w4 got %h exp 0", obs4);
    end
    checks++;
    reset = 1'b1;
    cyc = 0;
  endtask

  task automatic test_basic();
    do_reset();
    meas_ready_i = 1'b1;
    go(10); tick(1'b1, 1'b0);
    go(13); tick(1'b0, 1'b1);
    go(20);
    if (meas_valid_o !== 1'b0) begin
      errors++; $display("FAIL basic_no_early_valid got %b exp 0", meas_valid_o);
    end
    checks++;
    tick(1'b1, 1'b0);
    if (obs !== {1'b1, 16'd3, 16'd10, 1'b0, 1'b0}) begin
      errors++; $display("FAIL basic_out got %h exp %h", obs, {1'b1, 16'd3, 16'd10, 1'b0, 1'b0});
    end
    checks++;
    tick(1'b0, 1'b0);
    if (meas_valid_o !== 1'b0) begin
      errors++; $display("FAIL basic_valid_drop got %b exp 0", meas_valid_o);
    end
    checks++;
  endtask

  task automatic test_drop();
    do_reset();
    meas_ready_i = 1'b0;
    go(2);  tick(1'b1, 1'b0);
    go(5);  tick(1'b0, 1'b1);
    go(10); tick(1'b1, 1'b0);
    if (obs !== {1'b1, 16'd3, 16'd8, 1'b0, 1'b0}) begin
      errors++; $display("FAIL drop_first got %h exp %h", obs, {1'b1, 16'd3, 16'd8, 1'b0, 1'b0});
    end
    checks++;
    go(13); tick(1'b0, 1'b1);
    go(18); tick(1'b1, 1'b0);
    if (obs !== {1'b1, 16'd3, 16'd8, 1'b0, 1'b1}) begin
      errors++; $display("FAIL drop_pulse got %h exp %h", obs, {1'b1, 16'd3, 16'd8, 1'b0, 1'b1});
    end
    checks++;
    tick(1'b0, 1'b0);
    if (obs !== {1'b1, 16'd3, 16'd8, 1'b0, 1'b0}) begin
      errors++; $display("FAIL drop_one_cycle got %h exp %h", obs, {1'b1, 16'd3, 16'd8, 1'b0, 1'b0});
    end
    checks++;
    meas_ready_i = 1'b1;
    tick(1'b0, 1'b0);
    if (meas_valid_o !== 1'b0) begin
      errors++; $display("FAIL drop_accept got %b exp 0", meas_valid_o);
    end
    checks++;
  endtask

  task automatic test_saturation();
    do_reset();
    meas_ready_i = 1'b1;
    go(1);  tick(1'b1, 1'b0);
    go(21); tick(1'b0, 1'b1);
    go(46); tick(1'b1, 1'b0);
    if (obs4 !== {1'b1, 4'd15, 4'd15, 1'b1, 1'b0}) begin
      errors++; $display("FAIL sat_w4 got %h exp %h", obs4, {1'b1, 4'd15, 4'd15, 1'b1, 1'b0});
    end
    checks++;
    if (obs !== {1'b1, 16'd20, 16'd45, 1'b0, 1'b0}) begin
      errors++; $display("FAIL sat_w16 got %h exp %h", obs, {1'b1, 16'd20, 16'd45, 1'b0, 1'b0});
    end
    checks++;
  endtask

  task automatic test_missed_fall();
    int seen;
    do_reset();
    meas_ready_i = 1'b1;
    seen = 0;
    go(5); tick(1'b1, 1'b0);
    go(9); tick(1'b1, 1'b0);
    if (meas_valid_o !== 1'b0) begin
      errors++; $display("FAIL missed_c10 got %b exp 0", meas_valid_o);
    end
    checks++;
    go(12); tick(1'b0, 1'b1);
    while (cyc < 15) begin
      if (meas_valid_o !== 1'b0) seen++;
      tick(1'b0, 1'b0);
    end
    if (seen !== 0) begin
      errors++; $display("FAIL missed_quiet got %0d valid cycles exp 0", seen);
    end
    checks++;
    tick(1'b1, 1'b0);
    if (obs !== {1'b1, 16'd3, 16'd6, 1'b0, 1'b0}) begin
      errors++; $display("FAIL missed_out got %h exp %h", obs, {1'b1, 16'd3, 16'd6, 1'b0, 1'b0});
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    meas_ready_i = 1'b0;
    go(1); tick(1'b1, 1'b0);
    go(2); tick(1'b0, 1'b1);
    go(4); tick(1'b1, 1'b0);
    if (obs !== {1'b1, 16'd1, 16'd3, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rmid_held got %h exp %h", obs, {1'b1, 16'd1, 16'd3, 1'b0, 1'b0});
    end
    checks++;
    tick(1'b1, 1'b0);
    go(8);
    reset = 1'b0;
    #1;
    if (obs !== 35'd0) begin
      errors++; $display("FAIL rmid_async got %h exp 0", obs);
    end
    checks++;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    if (obs !== 35'd0) begin
      errors++; $display("FAIL rmid_held_low got %h exp 0", obs);
    end
    checks++;
    reset = 1'b1;
    meas_ready_i = 1'b1;
    go(12); tick(1'b0, 1'b1);
    go(14); tick(1'b1, 1'b0);
    go(16); tick(1'b0, 1'b1);
    go(20);
    if (meas_valid_o !== 1'b0) begin
      errors++; $display("FAIL rmid_no_early got %b exp 0", meas_valid_o);
    end
    checks++;
    tick(1'b1, 1'b0);
    if (obs !== {1'b1, 16'd2, 16'd6, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rmid_out got %h exp %h", obs, {1'b1, 16'd2, 16'd6, 1'b0, 1'b0});
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    meas_ready_i = 1'b0;
    go(2);  tick(1'b1, 1'b0);
    go(4);  tick(1'b0, 1'b1);
    go(10); tick(1'b1, 1'b0);
    if (obs !== {1'b1, 16'd2, 16'd8, 1'b0, 1'b0}) begin
      errors++; $display("FAIL b2b_first got %h exp %h", obs, {1'b1, 16'd2, 16'd8, 1'b0, 1'b0});
    end
    checks++;
    go(15); tick(1'b0, 1'b1);
    go(20);
    meas_ready_i = 1'b1;
    tick(1'b1, 1'b0);
    if (obs !== {1'b1, 16'd5, 16'd10, 1'b0, 1'b0}) begin
      errors++; $display("FAIL b2b_second got %h exp %h", obs, {1'b1, 16'd5, 16'd10, 1'b0, 1'b0});
    end
    checks++;
    tick(1'b0, 1'b0);
    if (meas_valid_o !== 1'b0) begin
      errors++; $display("FAIL b2b_release got %b exp 0", meas_valid_o);
    end
    checks++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    meas_ready_i = 1'b1;
    tick(1'b1, 1'b1);
    go(2);  tick(1'b1, 1'b0);
    go(5);  tick(1'b1, 1'b1);
    go(7);  tick(1'b0, 1'b1);
    go(9);  tick(1'b1, 1'b1);
    go(12);
    if (meas_valid_o !== 1'b0) begin
      errors++; $display("FAIL simul_no_capture got %b exp 0", meas_valid_o);
    end
    checks++;
    tick(1'b1, 1'b0);
    if (obs !== {1'b1, 16'd5, 16'd10, 1'b0, 1'b0}) begin
      errors++; $display("FAIL simul_out got %h exp %h", obs, {1'b1, 16'd5, 16'd10, 1'b0, 1'b0});
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_drop();
    test_saturation();
    test_missed_fall();
    test_reset_mid();
    test_back_to_back();
    test_simultaneous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_meter.md
PULSE_METER -- requirements
Module: pulse_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the width of the measurement counters and outputs.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (block held in reset while reset == 0).
REQ-004 SHALL have port rising_edge_i, input, 1 bit: one-cycle pulse marking a 0->1 transition of the monitored signal.
REQ-005 SHALL have port falling_edge_i, input, 1 bit: one-cycle pulse marking a 1->0 transition of the monitored signal.
REQ-006 SHALL have port meas_valid_o, output, 1 bit: a measurement is presented on the output ports.
REQ-007 SHALL have port meas_ready_i, input, 1 bit: the consumer accepts the measurement when meas_valid_o && meas_ready_i.
REQ-008 SHALL have port high_cnt_o, output, CNT_W bits: high time in clk cycles.
REQ-009 SHALL have port period_cnt_o, output, CNT_W bits: period in clk cycles.
REQ-010 SHALL have port ovf_o, output, 1 bit: high_cnt_o or period_cnt_o saturated during this measurement.
REQ-011 SHALL have port drop_o, output, 1 bit: one-cycle pulse indicating a completed measurement was discarded.

Function
REQ-012 SHALL implement the FSM states IDLE, HIGH and LOW.
REQ-013 IDLE: rising_edge_i SHALL load hcnt=1 and pcnt=1, clear the internal ovf, and move to HIGH; falling_edge_i SHALL be ignored.
REQ-014 HIGH, no pulse: hcnt and pcnt SHALL each increment by 1, saturating at 2^CNT_W-1; reaching saturation SHALL set the internal ovf.
REQ-015 HIGH, falling_edge_i: pcnt SHALL increment, hcnt SHALL freeze, and the FSM SHALL move to LOW.
REQ-016 HIGH, rising_edge_i (missed falling edge): the FSM SHALL restart, with hcnt=pcnt=1 and ovf cleared, stay in HIGH, and emit no output.
REQ-017 LOW, no pulse or falling_edge_i: pcnt SHALL increment (saturating, setting ovf); a falling_edge_i here SHALL otherwise be ignored.
REQ-018 LOW, rising_edge_i: the FSM SHALL capture {hcnt, pcnt, ovf} (values before this cycle's update) as a completed measurement, restart with hcnt=pcnt=1 and ovf cleared, and move to HIGH.
REQ-019 Given a rise at cycle t0, a fall at tf and the next rise at t1, the captured measurement SHALL be high=tf-t0 and period=t1-t0 (unsaturated case).
REQ-020 rising_edge_i and falling_edge_i asserted in the same cycle SHALL both be ignored in every state; counting continues as in the no-pulse case.
REQ-021 The output register SHALL be loaded the cycle after capture, with meas_valid_o=1 from that cycle (latency 1 from the second rise).
REQ-022 While meas_valid_o=1, high_cnt_o, period_cnt_o and ovf_o SHALL remain stable until the handshake completes.
REQ-023 Handshake: meas_valid_o SHALL deassert on the cycle after meas_valid_o && meas_ready_i unless a new capture loads the register in that same cycle.
REQ-024 A capture while meas_valid_o && meas_ready_i SHALL load the new measurement with no gap and no drop.
REQ-025 A capture while meas_valid_o && !meas_ready_i SHALL discard the new measurement, keep the held one, and pulse drop_o for exactly one cycle, the cycle after capture.

Reset
REQ-026 While reset==0, the block SHALL force state=IDLE, hcnt=pcnt=0, internal ovf=0, meas_valid_o=0, high_cnt_o=0, period_cnt_o=0, ovf_o=0 and drop_o=0, regardless of clk.
REQ-027 Reset asserted mid-measurement SHALL discard the partial and any held measurement; after release, pulses SHALL be interpreted from IDLE.

Verification
REQ-028 CNT_W=16, ready=1, rise@10, fall@13, rise@20: the bench SHALL see meas_valid_o=1 at cycle 21 with high_cnt_o=3, period_cnt_o=10, ovf_o=0, and valid low at 22.
REQ-029 ready=0, three rises 8 cycles apart: the first measurement SHALL be held with period 8, and the second capture SHALL produce drop_o=1 for one cycle with held data unchanged.
REQ-030 CNT_W=4, rise, fall after 20 cycles, rise after 25 more: the measurement SHALL have high_cnt_o=15, period_cnt_o=15, ovf_o=1.
REQ-031 rise@5, rise@9 (no fall), fall@12, rise@15: no output SHALL appear at cycle 10; the first output SHALL be high=3, period=6.
REQ-032 rise@5, reset low at 8 and high at 10, fall@12, rise@14, fall@16, rise@20: all outputs SHALL be 0 during reset; the fall@12 SHALL be ignored; the first output SHALL be high=2, period=6.
REQ-033 Held measurement with ready=1 in the same cycle as a new capture: the new data SHALL appear the next cycle, valid SHALL stay high and drop_o SHALL remain 0.
